osd_spi_tx: RTL and testbench
=============================

Name: osd_spi_tx

Overview:
- SPI master that serialises OSD command/data bytes onto the OSD SPI link: SPI_SCK, SPI_SS3, and the data line consumed as SPI_DI by the osd instances.
- Lets an in-FPGA agent (menu engine, self-test, boot splash) draw the OSD without the IO controller.
- Its outputs are muxed with the external SPI pins ahead of the video pipeline.
- Transmit-only. Bytes arrive on a valid/ready stream; a tx_last flag delimits frames, and each frame is one SS3-low transaction.

Parameters:
- CLK_DIV, 4: SCK half-period in clk_sys cycles (≥1).
- CS_SETUP, 2: cycles from SS3 falling to the first SCK low phase starting (≥1).
- CS_HOLD, 2: cycles after the last SCK falling edge before SS3 rises (≥1).
- CS_GAP, 2: minimum SS3-high cycles between frames (≥1).
- TIMEOUT, 4096: stall limit in cycles (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send, MSB first
- tx_last  in  1  byte closes the frame
- tx_valid  in  1  byte offered
- tx_ready  out  1  byte accepted when tx_valid&tx_ready at a rising clk_sys edge
- busy  out  1  frame in progress (SS3 low, or in the GAP state)
- SPI_SCK  out  1  serial clock, idle low (mode 0)
- SPI_SS3  out  1  OSD select, active low
- SPI_DO  out  1  serial data into the receiver's SPI_DI
- timeout  out  1  one-cycle pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, any state): SPI_SS3=1, SPI_SCK=0, SPI_DO=0, tx_ready=0, busy=0, timeout=0, state=IDLE. tx_ready rises on the first clock after reset_n deasserts. A reset mid-byte aborts the byte; no partial completion.
- All outputs are registered.
- State IDLE: SS3=1, tx_ready=1. On handshake, latch the byte and last flag, then go to SETUP.
- State SETUP: SS3=0, SCK=0, SPI_DO=bit7, tx_ready=0. Lasts CS_SETUP cycles, then go to SHIFT.
- State SHIFT: 8 bits, each = CLK_DIV cycles SCK low followed by CLK_DIV cycles SCK high.
  - SPI_DO changes only at the start of a low phase, so it is stable across each rising edge.
  - Bit index counts 7 down to 0.
  - After bit0's high phase, SCK returns low. If last is set, go to HOLD; otherwise go to WAIT.
- State WAIT: SS3=0, SCK=0, tx_ready=1. Stays indefinitely while tx_valid=0, which is a legal stall.
  - On handshake, latch the byte, put bit7 on SPI_DO, and enter SHIFT directly (no SETUP).
- State HOLD: SS3=0, SCK=0 for CS_HOLD cycles, then go to GAP.
- State GAP: SS3=1, tx_ready=0 for CS_GAP cycles, then go to IDLE.
- tx_ready is asserted only in IDLE and WAIT. Input is ignored in all other states.
- tx_last is sampled only at the handshake.
- Timing per frame of N bytes:
  - SS3 low time = CS_SETUP + N×16×CLK_DIV + CS_HOLD + (WAIT stall cycles) + (N−1) handshake cycles in WAIT.
  - Bit k (k=0 for MSB) rises at SETUP-start + CS_SETUP + k×2×CLK_DIV + CLK_DIV.
- busy = (state ≠ IDLE).

Optional Feature:
- Macro: OSD_SPI_TX_TIMEOUT_EN.
- When defined, a counter runs while in WAIT and is cleared on every handshake.
  - When it reaches TIMEOUT, the block pulses timeout for one cycle and goes to GAP, dropping SS3 so the receiver sees an aborted frame.
  - The counter is 13 bits at the default TIMEOUT (width $clog2(TIMEOUT+1)).
- When undefined, WAIT never times out, the counter is not synthesised, and timeout is tied 0.

Decomposition:
- Package osd_spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, WAIT, HOLD, GAP);
  - OSD command constants: OSD_CMD_WRITE=8'h20, OSD_CMD_DISABLE=8'h40, OSD_CMD_ENABLE=8'h41.
- One sub-module, osd_spi_tick: the CLK_DIV phase counter, producing a half-period strobe, with a restart input asserted on entry to SHIFT.
- The FSM and shift register stay in osd_spi_tx.

Test Plan:
- Single byte, defaults: 8'hA5 with last=1 → SS3 low for exactly 68 cycles. Eight SCK rising edges; SPI_DO at the rising edges = 1,0,1,0,0,1,0,1. tx_ready low for 70 cycles after the handshake. SCK is never high while SS3 is high.
- Two-byte frame, CLK_DIV=1: 8'h41 (last=0) then 8'h20 (last=1) offered back-to-back → one SS3-low window. 16 rising edges carry 0x41 then 0x20. No SETUP between bytes.
- WAIT stall: 8'h20 (last=0), tx_valid held 0 for 500 cycles, then 8'h00 (last=1) → SS3 stays low and SCK stays 0 during the stall; the second byte is clocked out intact.
- Reset mid-operation: assert reset_n=0 after the 3rd rising SCK edge → SS3=1, SCK=0, SPI_DO=0 in the same cycle (asynchronous). A following frame of 8'hFF is transmitted correctly.
- Back-pressure: tx_valid held high with changing tx_data during SHIFT → tx_ready stays 0 and the transmitted byte equals the value latched at the handshake.
- With OSD_SPI_TX_TIMEOUT_EN and TIMEOUT=16: 8'h20 (last=0) then no data → timeout pulses once on the 16th WAIT cycle, SS3 rises, and tx_ready returns after CS_GAP cycles.

Source files
------------

// File: rtl/osd_spi_pkg.sv
// Shared types and OSD command bytes for the in-FPGA OSD SPI master.
package osd_spi_pkg;

  typedef logic [7:0] osd_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    WAIT,
    HOLD,
    GAP
  } osd_spi_state_e;

  localparam osd_byte_t OSD_CMD_WRITE   = 8'h20;
  localparam osd_byte_t OSD_CMD_DISABLE = 8'h40;
  localparam osd_byte_t OSD_CMD_ENABLE  = 8'h41;

endpackage

// File: rtl/osd_spi_tx_if.sv
// Byte stream into the OSD SPI master: valid/ready handshake with a frame-closing last flag.
interface osd_spi_tx_if;

  osd_spi_pkg::osd_byte_t tx_data;
  logic                   tx_last;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);

endinterface

// File: rtl/osd_spi_tick.sv
// SCK half-period timer: tick_o marks the last clk_sys cycle of each CLK_DIV-cycle phase.
module osd_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q;

  // Restart aligns the first phase of a byte to the cycle SHIFT is entered.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/osd_spi_tx.sv
// Transmit-only SPI master (mode 0) driving the OSD SS3 link from an in-FPGA byte stream.
// Optional stall watchdog in WAIT: define OSD_SPI_TX_TIMEOUT_EN.
module osd_spi_tx
  import osd_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  osd_spi_tx_if.slave  tx,
  output logic         busy,
  output logic         SPI_SCK,
  output logic         SPI_SS3,
  output logic         SPI_DO,
  output logic         timeout
);

  osd_spi_state_e state_q;
  logic [15:0]    cnt_q;
  logic [2:0]     bit_q;
  logic [6:0]     sh_q;
  logic           last_q;
  logic           sck_q;
  logic           ss3_q;
  logic           do_q;
  logic           ready_q;
  logic           busy_q;
  logic           handshake;
  logic           restart;
  logic           tick;

`ifdef OSD_SPI_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q;
  logic          timeout_q;
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  assign handshake = tx.tx_valid & ready_q;
  assign restart   = ((state_q == SETUP) && (cnt_q == 16'(CS_SETUP - 1))) ||
                     ((state_q == WAIT) && handshake);

  osd_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Outputs are set together with the state they belong to, so every pin is a flop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      ss3_q   <= 1'b1;
      do_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef OSD_SPI_TX_TIMEOUT_EN
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef OSD_SPI_TX_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (handshake) begin
            sh_q    <= tx.tx_data[6:0];
            do_q    <= tx.tx_data[7];
            last_q  <= tx.tx_last;
            ss3_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 16'(CS_SETUP - 1)) begin
            bit_q   <= 3'd7;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              if (bit_q == 3'd0) begin
                cnt_q <= '0;
                if (last_q) begin
                  state_q <= HOLD;
                end else begin
                  ready_q <= 1'b1;
`ifdef OSD_SPI_TX_TIMEOUT_EN
                  wcnt_q  <= '0;
`endif
                  state_q <= WAIT;
                end
              end else begin
                bit_q <= bit_q - 3'd1;
                do_q  <= sh_q[6];
                sh_q  <= {sh_q[5:0], 1'b0};
              end
            end
          end
        end
        WAIT: begin
          if (handshake) begin
            sh_q    <= tx.tx_data[6:0];
            do_q    <= tx.tx_data[7];
            last_q  <= tx.tx_last;
            ready_q <= 1'b0;
            bit_q   <= 3'd7;
`ifdef OSD_SPI_TX_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
            state_q <= SHIFT;
          end
`ifdef OSD_SPI_TX_TIMEOUT_EN
          // Abandon a stalled frame; SS3 rising tells the receiver it was cut short.
          else if (wcnt_q == TW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            ss3_q     <= 1'b1;
            do_q      <= 1'b0;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            state_q   <= GAP;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (cnt_q == 16'(CS_HOLD - 1)) begin
            ss3_q   <= 1'b1;
            do_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == 16'(CS_GAP - 1)) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_ready = ready_q;
  assign busy        = busy_q;
  assign SPI_SCK     = sck_q;
  assign SPI_SS3     = ss3_q;
  assign SPI_DO      = do_q;

`ifdef OSD_SPI_TX_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_osd_spi_tx.sv
// Directed bench for osd_spi_tx: instance A uses defaults, instance B runs CLK_DIV=1, TIMEOUT=16.
module tb_osd_spi_tx;
  import osd_spi_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] txData  = 8'h00;
  logic       txLast  = 1'b0;
  logic       txValid = 1'b0;
  logic       useB    = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  osd_spi_tx_if ifA ();
  osd_spi_tx_if ifB ();

  assign ifA.tx_data  = txData;
  assign ifA.tx_last  = txLast;
  assign ifA.tx_valid = txValid & ~useB;
  assign ifB.tx_data  = txData;
  assign ifB.tx_last  = txLast;
  assign ifB.tx_valid = txValid & useB;

  logic busyA, sckA, ss3A, doA, toA;
  logic busyB, sckB, ss3B, doB, toB;

  osd_spi_tx dutA (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tx      (ifA),
    .busy    (busyA),
    .SPI_SCK (sckA),
    .SPI_SS3 (ss3A),
    .SPI_DO  (doA),
    .timeout (toA)
  );

  osd_spi_tx #(.CLK_DIV(1), .TIMEOUT(16)) dutB (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tx      (ifB),
    .busy    (busyB),
    .SPI_SCK (sckB),
    .SPI_SS3 (ss3B),
    .SPI_DO  (doB),
    .timeout (toB)
  );

  wire sck   = useB ? sckB : sckA;
  wire ss3   = useB ? ss3B : ss3A;
  wire dout  = useB ? doB : doA;
  wire ready = useB ? ifB.tx_ready : ifA.tx_ready;
  wire busy  = useB ? busyB : busyA;
  wire toSig = useB ? toB : toA;

  logic [7:0]  qData [4];
  logic        qLast [4];
  int          ss3Low, readyLow, rises, ss3Rises, sckBad, stallBad;
  int          timeoutPulses, timeoutStep, readyBackStep;
  int          riseStep [16];
  logic [15:0] rxBits;

  // Plays qData/qLast into the selected DUT and records pin activity, one sample per negedge.
  task automatic runFrame(input int nBytes, input int stallSteps, input int junkSteps, input int maxSteps);
    int idx;
    int stallLeft;
    int junkLeft;
    bit taken;
    bit prevSs3;
    bit prevSck;
    idx = 0; stallLeft = 0; junkLeft = junkSteps;
    ss3Low = 0; readyLow = 0; rises = 0; ss3Rises = 0; sckBad = 0; stallBad = 0;
    timeoutPulses = 0; timeoutStep = 0; readyBackStep = 0; rxBits = '0;
    for (int i = 0; i < 16; i++) riseStep[i] = 0;
    txData = qData[0]; txLast = qLast[0]; txValid = 1'b1;
    taken = txValid && ready;
    prevSs3 = ss3; prevSck = sck;
    for (int step = 1; step <= maxSteps; step++) begin
      @(negedge clk_sys);
      if (!ss3) ss3Low++;
      if (!ready) readyLow++;
      if (ss3 && !prevSs3) ss3Rises++;
      if (sck && ss3) sckBad++;
      if (sck && !prevSck) begin
        if (rises < 16) riseStep[rises] = step;
        rises++;
        rxBits = {rxBits[14:0], dout};
      end
      if (toSig) begin
        timeoutPulses++;
        timeoutStep = step;
      end
      if (timeoutStep != 0 && step > timeoutStep && ready && readyBackStep == 0) readyBackStep = step;
      if (stallLeft > 0 && step > 70 && (sck || ss3)) stallBad++;
      prevSs3 = ss3; prevSck = sck;
      if (taken) begin
        idx++;
        if (idx < nBytes) begin
          if (stallSteps > 0) begin
            stallLeft = stallSteps;
            txValid = 1'b0;
          end else begin
            txData = qData[idx]; txLast = qLast[idx];
          end
        end else if (junkLeft == 0) begin
          txValid = 1'b0;
        end
      end else if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) begin
          txData = qData[idx]; txLast = qLast[idx]; txValid = 1'b1;
        end
      end
      if (idx >= nBytes && junkLeft > 0) begin
        junkLeft--;
        txData = 8'(step * 37 + 1);
        txLast = 1'(step);
        if (junkLeft == 0) txValid = 1'b0;
      end
      taken = txValid && ready;
    end
    txValid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++; if (ss3A !== 1'b1) begin errors++; $display("[TB] FAIL reset_ss3: got %b expected 1", ss3A); end
    checks++; if (sckA !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck: got %b expected 0", sckA); end
    checks++; if (doA !== 1'b0) begin errors++; $display("[TB] FAIL reset_do: got %b expected 0", doA); end
    checks++; if (ifA.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ifA.tx_ready); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
    checks++; if (toA !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", toA); end
    checks++; if (ss3B !== 1'b1 || busyB !== 1'b0) begin errors++; $display("[TB] FAIL reset_b: got ss3=%b busy=%b expected ss3=1 busy=0", ss3B, busyB); end
    reset_n = 1'b1;
    #1;
    checks++; if (ifA.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_ready_early: got %b expected 0", ifA.tx_ready); end
    @(negedge clk_sys);
    checks++; if (ifA.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", ifA.tx_ready); end
    checks++; if (ifB.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready_b: got %b expected 1", ifB.tx_ready); end
  endtask

  task automatic test_single_byte();
    useB = 1'b0;
    qData[0] = 8'hA5; qLast[0] = 1'b1;
    runFrame(1, 0, 0, 100);
    checks++; if (ss3Low !== 68) begin errors++; $display("[TB] FAIL single_ss3_low: got %0d expected 68", ss3Low); end
    checks++; if (readyLow !== 70) begin errors++; $display("[TB] FAIL single_ready_low: got %0d expected 70", readyLow); end
    checks++; if (rises !== 8) begin errors++; $display("[TB] FAIL single_rises: got %0d expected 8", rises); end
    checks++; if (rxBits[7:0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h expected a5", rxBits[7:0]); end
    checks++; if (riseStep[0] !== 7) begin errors++; $display("[TB] FAIL single_first_rise: got %0d expected 7", riseStep[0]); end
    checks++; if (riseStep[7] !== 63) begin errors++; $display("[TB] FAIL single_last_rise: got %0d expected 63", riseStep[7]); end
    checks++; if (sckBad !== 0) begin errors++; $display("[TB] FAIL single_sck_while_deselected: got %0d expected 0", sckBad); end
    checks++; if (ss3Rises !== 1) begin errors++; $display("[TB] FAIL single_ss3_windows: got %0d expected 1", ss3Rises); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_two_byte();
    useB = 1'b1;
    qData[0] = OSD_CMD_ENABLE; qLast[0] = 1'b0;
    qData[1] = OSD_CMD_WRITE;  qLast[1] = 1'b1;
    runFrame(2, 0, 0, 60);
    checks++; if (ss3Low !== 37) begin errors++; $display("[TB] FAIL two_ss3_low: got %0d expected 37", ss3Low); end
    checks++; if (rises !== 16) begin errors++; $display("[TB] FAIL two_rises: got %0d expected 16", rises); end
    checks++; if (rxBits !== 16'h4120) begin errors++; $display("[TB] FAIL two_data: got %h expected 4120", rxBits); end
    checks++; if (riseStep[0] !== 4) begin errors++; $display("[TB] FAIL two_first_rise: got %0d expected 4", riseStep[0]); end
    checks++; if (riseStep[8] !== 21) begin errors++; $display("[TB] FAIL two_second_byte_rise: got %0d expected 21", riseStep[8]); end
    checks++; if (ss3Rises !== 1) begin errors++; $display("[TB] FAIL two_ss3_windows: got %0d expected 1", ss3Rises); end
    useB = 1'b0;
  endtask

  task automatic test_wait_stall();
    useB = 1'b0;
    qData[0] = OSD_CMD_WRITE; qLast[0] = 1'b0;
    qData[1] = 8'h00;         qLast[1] = 1'b1;
    runFrame(2, 500, 0, 650);
    checks++; if (ss3Low !== 567) begin errors++; $display("[TB] FAIL stall_ss3_low: got %0d expected 567", ss3Low); end
    checks++; if (rises !== 16) begin errors++; $display("[TB] FAIL stall_rises: got %0d expected 16", rises); end
    checks++; if (rxBits !== 16'h2000) begin errors++; $display("[TB] FAIL stall_data: got %h expected 2000", rxBits); end
    checks++; if (riseStep[8] !== 506) begin errors++; $display("[TB] FAIL stall_second_byte_rise: got %0d expected 506", riseStep[8]); end
    checks++; if (stallBad !== 0) begin errors++; $display("[TB] FAIL stall_pins: got %0d expected 0", stallBad); end
    checks++; if (timeoutPulses !== 0) begin errors++; $display("[TB] FAIL stall_timeout: got %0d expected 0", timeoutPulses); end
  endtask

  task automatic test_reset_mid_byte();
    bit prevSck;
    int seen;
    int budget;
    useB = 1'b0;
    txData = 8'hA5; txLast = 1'b1; txValid = 1'b1;
    prevSck = sckA; seen = 0; budget = 0;
    while (seen < 3 && budget < 200) begin
      @(negedge clk_sys);
      txValid = 1'b0;
      if (sckA && !prevSck) seen++;
      prevSck = sckA;
      budget++;
    end
    checks++; if (seen !== 3) begin errors++; $display("[TB] FAIL midreset_edges: got %0d expected 3", seen); end
    checks++; if (doA !== 1'b1 || sckA !== 1'b1) begin errors++; $display("[TB] FAIL midreset_before: got sck=%b do=%b expected sck=1 do=1", sckA, doA); end
    reset_n = 1'b0;
    #1;
    checks++; if (ss3A !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ss3: got %b expected 1", ss3A); end
    checks++; if (sckA !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sck: got %b expected 0", sckA); end
    checks++; if (doA !== 1'b0) begin errors++; $display("[TB] FAIL midreset_do: got %b expected 0", doA); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    qData[0] = 8'hFF; qLast[0] = 1'b1;
    runFrame(1, 0, 0, 100);
    checks++; if (rxBits[7:0] !== 8'hFF) begin errors++; $display("[TB] FAIL midreset_next_data: got %h expected ff", rxBits[7:0]); end
    checks++; if (rises !== 8) begin errors++; $display("[TB] FAIL midreset_next_rises: got %0d expected 8", rises); end
    checks++; if (ss3Low !== 68) begin errors++; $display("[TB] FAIL midreset_next_ss3_low: got %0d expected 68", ss3Low); end
  endtask

  task automatic test_back_pressure();
    useB = 1'b0;
    qData[0] = 8'h3C; qLast[0] = 1'b1;
    runFrame(1, 0, 60, 100);
    checks++; if (rxBits[7:0] !== 8'h3C) begin errors++; $display("[TB] FAIL bp_data: got %h expected 3c", rxBits[7:0]); end
    checks++; if (rises !== 8) begin errors++; $display("[TB] FAIL bp_rises: got %0d expected 8", rises); end
    checks++; if (readyLow !== 70) begin errors++; $display("[TB] FAIL bp_ready_low: got %0d expected 70", readyLow); end
    checks++; if (ss3Rises !== 1) begin errors++; $display("[TB] FAIL bp_ss3_windows: got %0d expected 1", ss3Rises); end
  endtask

`ifdef OSD_SPI_TX_TIMEOUT_EN
  task automatic test_timeout();
    useB = 1'b1;
    qData[0] = OSD_CMD_WRITE; qLast[0] = 1'b0;
    runFrame(1, 0, 0, 60);
    checks++; if (timeoutPulses !== 1) begin errors++; $display("[TB] FAIL to_pulses: got %0d expected 1", timeoutPulses); end
    checks++; if (timeoutStep !== 35) begin errors++; $display("[TB] FAIL to_step: got %0d expected 35", timeoutStep); end
    checks++; if (ss3Low !== 34) begin errors++; $display("[TB] FAIL to_ss3_low: got %0d expected 34", ss3Low); end
    checks++; if (readyBackStep !== 37) begin errors++; $display("[TB] FAIL to_ready_back: got %0d expected 37", readyBackStep); end
    checks++; if (rxBits[7:0] !== 8'h20) begin errors++; $display("[TB] FAIL to_data: got %h expected 20", rxBits[7:0]); end
    useB = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_wait_stall();
    test_reset_mid_byte();
    test_back_pressure();
`ifdef OSD_SPI_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
